// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM encodings and default timeout rule for multiplier monitoring
package mult_pkg;
    typedef enum logic [2:0] {IDLE, RUN, WAIT_A, WAIT_B, DONE, TOUT} state_t;
    function automatic int defaultMaxCycles(input int width);
        return 2 * width + 4;
    endfunction
endpackage

// File: rtl/latency_capture.sv
// latency_capture: first-done detect and latency register for one channel
module latency_capture #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sample,
    input  logic             done,
    input  logic             fill,
    input  logic [CNT_W-1:0] cnt,
    output logic             hit,
    output logic             got,
    output logic [CNT_W-1:0] lat
);
    assign hit = sample && done && !got;
    // capture the first sampled done; a channel still missing at timeout reads all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat <= '0;
            got <= 1'b0;
        end else if (clear) begin
            lat <= '0;
            got <= 1'b0;
        end else if (hit) begin
            lat <= cnt;
            got <= 1'b1;
        end else if (fill && !got) begin
            lat <= '1;
        end
    end
endmodule

// File: rtl/mult_latency_monitor.sv
// mult_latency_monitor: compares latency and result of two multipliers sharing one start
module mult_latency_monitor
    import mult_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX_CYCLES = defaultMaxCycles(WIDTH),
    localparam int CNT_W = $clog2(MAX_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               doneA,
    input  logic               doneB,
    input  logic [2*WIDTH-1:0] productA,
    input  logic [2*WIDTH-1:0] productB,
    output logic               busy,
    output logic [CNT_W-1:0]   latA,
    output logic [CNT_W-1:0]   latB,
    output logic               timingLeak,
    output logic               timingLeakDone,
    output logic               mismatch,
    output logic               timeout
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYCLES);
    state_t state, stateNext;
    logic active, startOk, hitA, hitB, gotA, gotB, haveA, haveB, fill, finish;
    logic [CNT_W-1:0] cnt, cntNext;
    assign active = state inside {RUN, WAIT_A, WAIT_B};
    assign startOk = start && !active;
    assign cntNext = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign haveA = gotA || hitA;
    assign haveB = gotB || hitB;
    assign fill = active && stateNext == TOUT;
    assign finish = stateNext inside {DONE, TOUT};
    latency_capture #(.CNT_W(CNT_W)) capA (
        .clk(clk), .rst(rst), .clear(startOk), .sample(active), .done(doneA),
        .fill(fill), .cnt(cntNext), .hit(hitA), .got(gotA), .lat(latA)
    );
    latency_capture #(.CNT_W(CNT_W)) capB (
        .clk(clk), .rst(rst), .clear(startOk), .sample(active), .done(doneB),
        .fill(fill), .cnt(cntNext), .hit(hitB), .got(gotB), .lat(latB)
    );
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= stateNext;
    end
    // a completing done outranks the timeout landing in the same cycle
    always_comb begin
        stateNext = state;
        if (startOk) stateNext = RUN;
        else if (active)
            stateNext = (haveA && haveB) ? DONE :
                        (cntNext == CNT_MAX) ? TOUT :
                        haveA ? WAIT_B : haveB ? WAIT_A : RUN;
    end
    // counter and result flags, all registered and held after finishing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            busy <= 1'b0;
            timingLeak <= 1'b0;
            timingLeakDone <= 1'b0;
            mismatch <= 1'b0;
            timeout <= 1'b0;
        end else if (startOk) begin
            cnt <= '0;
            busy <= 1'b1;
            timingLeak <= 1'b0;
            timingLeakDone <= 1'b0;
            mismatch <= 1'b0;
            timeout <= 1'b0;
        end else if (active) begin
            cnt <= cntNext;
            busy <= !finish;
            timingLeak <= timingLeak || (haveA != haveB);
            timingLeakDone <= finish;
            mismatch <= stateNext == DONE && productA != productB;
            timeout <= stateNext == TOUT;
        end
    end
endmodule

// File: tb/tb_mult_latency_monitor.sv
// tb_mult_latency_monitor: directed checks of latency, leak, mismatch, timeout and reset
module tb_mult_latency_monitor;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, doneA = 1'b0, doneB = 1'b0;
    logic [7:0] productA = '0, productB = '0;
    logic busy, timingLeak, timingLeakDone, mismatch, timeout;
    logic [3:0] latA, latB;
    int total = 0, bad = 0;

    mult_latency_monitor #(.WIDTH(4), .MAX_CYCLES(12)) dut (
        .clk(clk), .rst(rst), .start(start), .doneA(doneA), .doneB(doneB),
        .productA(productA), .productB(productB), .busy(busy), .latA(latA), .latB(latB),
        .timingLeak(timingLeak), .timingLeakDone(timingLeakDone),
        .mismatch(mismatch), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_latA", latA, 0);
        check("rst_latB", latB, 0);
        check("rst_flags", {timingLeak, timingLeakDone, mismatch, timeout}, 0);
        rst = 1'b0;
        tick(1);

        productA = 8'h2A; productB = 8'h2A;
        go();
        check("t1_busy", busy, 1);
        tick(7);
        check("t1_tld_early", timingLeakDone, 0);
        doneA = 1; doneB = 1;
        tick(1);
        doneA = 0; doneB = 0;
        check("t1_latA", latA, 8);
        check("t1_latB", latB, 8);
        check("t1_leak", timingLeak, 0);
        check("t1_mis", mismatch, 0);
        check("t1_tld", timingLeakDone, 1);
        check("t1_busy_end", busy, 0);
        check("t1_tout", timeout, 0);

        go();
        check("t2_cleared", {timingLeakDone, latA, latB}, 0);
        tick(4);
        doneA = 1;
        tick(1);
        check("t2_leak", timingLeak, 1);
        check("t2_latA", latA, 5);
        check("t2_tld_mid", timingLeakDone, 0);
        tick(2);
        doneB = 1;
        tick(1);
        doneA = 0; doneB = 0;
        check("t2_latA_hold", latA, 5);
        check("t2_latB", latB, 8);
        check("t2_tld", timingLeakDone, 1);
        check("t2_mis", mismatch, 0);

        productA = 8'h0C; productB = 8'h0D;
        go();
        tick(2);
        doneA = 1; doneB = 1;
        tick(1);
        doneA = 0; doneB = 0;
        check("t3_mis", mismatch, 1);
        check("t3_leak", timingLeak, 0);
        check("t3_lat", {latA, latB}, 8'h33);

        productB = 8'h0C;
        go();
        tick(1);
        doneA = 1;
        tick(1);
        doneA = 0;
        tick(9);
        check("t4_busy_e11", {busy, timeout}, 2'b10);
        tick(1);
        check("t4_tout", timeout, 1);
        check("t4_tld", timingLeakDone, 1);
        check("t4_leak", timingLeak, 1);
        check("t4_latB", latB, 4'hF);
        check("t4_latA", latA, 2);
        check("t4_busy", busy, 0);
        doneB = 1;
        tick(3);
        doneB = 0;
        check("t4_hold", {latB, timeout, busy}, {4'hF, 1'b1, 1'b0});

        go();
        tick(2);
        start = 1;
        tick(1);
        start = 0;
        tick(2);
        doneA = 1; doneB = 1;
        tick(1);
        doneA = 0; doneB = 0;
        check("t5_restart_ignored", {latA, latB}, 8'h66);

        go();
        tick(3);
        doneB = 1;
        tick(1);
        doneB = 0;
        tick(7);
        doneA = 1;
        tick(1);
        doneA = 0;
        check("t6_prio_tout", timeout, 0);
        check("t6_prio_lat", {latA, latB}, 8'hC4);
        check("t6_prio_tld", timingLeakDone, 1);

        go();
        tick(2);
        doneA = 1;
        tick(1);
        doneA = 0;
        tick(1);
        rst = 1;
        #2;
        check("t7_async", {busy, latA, latB, timingLeak, timingLeakDone, mismatch, timeout}, 0);
        tick(1);
        rst = 0;
        tick(1);
        go();
        tick(2);
        doneA = 1; doneB = 1;
        tick(1);
        doneA = 0; doneB = 0;
        check("t7_fresh", {latA, latB, timingLeak, timingLeakDone}, {8'h33, 1'b0, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_latency_monitor.md
MULT_LATENCY_MONITOR -- requirements
Module: mult_latency_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the operand width of each observed multiplier.
REQ-002 SHALL have parameter MAX_CYCLES, default 2*WIDTH+4, the timeout bound in cycles after start.
REQ-003 SHALL derive localparam CNT_W = clog2(MAX_CYCLES+1), the counter and latency width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  the same start pulse driven to both observed multipliers.
REQ-007 SHALL have port doneA  input  1  productDone of multiplier A.
REQ-008 SHALL have port doneB  input  1  productDone of multiplier B.
REQ-009 SHALL have port productA  input  2*WIDTH  product of multiplier A.
REQ-010 SHALL have port productB  input  2*WIDTH  product of multiplier B.
REQ-011 SHALL have port busy  output  1  high while a measurement is in progress.
REQ-012 SHALL have port latA  output  CNT_W  captured latency of A.
REQ-013 SHALL have port latB  output  CNT_W  captured latency of B.
REQ-014 SHALL have port timingLeak  output  1  sticky flag: A and B did not finish in the same cycle.
REQ-015 SHALL have port timingLeakDone  output  1  timingLeak is final and valid.
REQ-016 SHALL have port mismatch  output  1  the products differed when both finished.
REQ-017 SHALL have port timeout  output  1  MAX_CYCLES elapsed before both finished.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, WAIT_A, WAIT_B, DONE and TOUT, all outputs registered.
REQ-019 SHALL, on start in IDLE, DONE or TOUT, enter RUN, clear cnt, latA, latB and all flags, and set busy the next cycle.
REQ-020 SHALL ignore start in RUN, WAIT_A and WAIT_B; it SHALL NOT restart or clear the measurement.
REQ-021 SHALL increment cnt by 1 every cycle in RUN, WAIT_A and WAIT_B, so cnt=1 in the first cycle after start, saturating at MAX_CYCLES.
REQ-022 SHALL sample doneA/doneB only in RUN/WAIT_*; the first sampled high level captures latX=cnt, and later highs are ignored.
REQ-023 SHALL, in RUN: if both dones are high, capture both and go to DONE; if only doneA, go to WAIT_B and set timingLeak; if only doneB, go to WAIT_A and set timingLeak.
REQ-024 SHALL, in WAIT_A/WAIT_B, go to DONE when the missing done arrives.
REQ-025 SHALL, on entering DONE, set mismatch = (productA != productB) sampled that same cycle, set timingLeakDone=1, and clear busy.
REQ-026 SHALL, when cnt reaches MAX_CYCLES in RUN/WAIT_* with no completing done, enter TOUT with timeout=1, timingLeakDone=1 and busy=0; an uncaptured latX SHALL read all-ones.
REQ-027 SHALL give a done arriving in the same cycle as the timeout priority, so the state goes to DONE, not TOUT.
REQ-028 SHALL hold all results stable in DONE/TOUT until the next accepted start.
REQ-029 SHALL NOT set timingLeak when both dones rise in the same cycle (equal latency).

Reset
REQ-030 SHALL, on rst asynchronously, enter IDLE, zero cnt, latA and latB, and drive busy, timingLeak, timingLeakDone, mismatch and timeout to 0.
REQ-031 SHALL, on rst mid-measurement, abandon the measurement, and the next start after rst release SHALL begin a clean run.

Structure
REQ-032 SHALL place the FSM state encodings and the default MAX_CYCLES rule in shared package mult_pkg, which the multiplier bench also uses.
REQ-033 SHALL instantiate sub-module latency_capture twice (one per channel): first-done detect plus latency register.

Verification
REQ-034 SHALL verify, with WIDTH=4: start, doneA and doneB both high at cycle 8 with products 0x2A/0x2A -> latA=latB=8, timingLeak=0, mismatch=0, timingLeakDone=1 next cycle.
REQ-035 SHALL verify: doneA at cycle 5, doneB at cycle 8 -> timingLeak=1 from cycle 6, latA=5, latB=8, timingLeakDone=1 after cycle 8.
REQ-036 SHALL verify: products 0x0C vs 0x0D at simultaneous done -> mismatch=1, timingLeak=0.
REQ-037 SHALL verify: doneA only, MAX_CYCLES=12 -> TOUT at cnt=12, timeout=1, timingLeak=1, latB=all-ones.
REQ-038 SHALL verify: start repeated at cycle 3 in RUN -> ignored, latencies still measured from the original start.
REQ-039 SHALL verify: rst asserted at cycle 4 of RUN -> all outputs 0 immediately; a fresh start then measures correctly.
